// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master / one-slave AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read+write)
// share one slave port, one transaction at a time, round-robin on simultaneous requests.
module ysyx_25020037_axi_arbiter (
  input  logic        clk,
  input  logic        rst,
  // m0 (IFU) AR / R
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic [3:0]  m0_rid,
  input  logic        m0_rready,
  // m1 (LSU) AR / R
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic [3:0]  m1_rid,
  input  logic        m1_rready,
  // m1 (LSU) AW / W / B
  input  logic        m1_awvalid,
  input  logic [31:0] m1_awaddr,
  input  logic [3:0]  m1_awid,
  input  logic [7:0]  m1_awlen,
  input  logic [2:0]  m1_awsize,
  input  logic [1:0]  m1_awburst,
  output logic        m1_awready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wlast,
  output logic        m1_wready,
  output logic        m1_bvalid,
  output logic [1:0]  m1_bresp,
  output logic [3:0]  m1_bid,
  input  logic        m1_bready,
  // slave side
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,
  input  logic [3:0]  s_rid,
  output logic        s_rready,
  output logic        s_awvalid,
  output logic [31:0] s_awaddr,
  output logic [3:0]  s_awid,
  output logic [7:0]  s_awlen,
  output logic [2:0]  s_awsize,
  output logic [1:0]  s_awburst,
  input  logic        s_awready,
  output logic        s_wvalid,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wlast,
  input  logic        s_wready,
  input  logic        s_bvalid,
  input  logic [1:0]  s_bresp,
  input  logic [3:0]  s_bid,
  output logic        s_bready
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

  state_t r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last_grant, w_last_grant_nxt;
  logic   w_req0, w_req1, w_win, w_own_rready;

  assign w_req0       = m0_arvalid;
  assign w_req1       = m1_arvalid | m1_awvalid;
  // On a tie the master that did not win last time takes the grant.
  assign w_win        = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
  assign w_own_rready = r_owner ? m1_rready : m0_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;

    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_owner_nxt      = w_win;
          w_last_grant_nxt = w_win;
          // An LSU holding both AR and AW is served read-first.
          w_state_nxt      = (w_win & ~m1_arvalid) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (!r_owner) begin
          s_arvalid  = m0_arvalid;
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
          m0_rvalid  = s_rvalid;
          m0_rdata   = s_rdata;
          m0_rresp   = s_rresp;
          m0_rlast   = s_rlast;
          m0_rid     = s_rid;
        end else begin
          s_arvalid  = m1_arvalid;
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
          m1_rvalid  = s_rvalid;
          m1_rdata   = s_rdata;
          m1_rresp   = s_rresp;
          m1_rlast   = s_rlast;
          m1_rid     = s_rid;
        end
        s_rready = w_own_rready;
        if (s_rvalid & w_own_rready & s_rlast) w_state_nxt = ST_IDLE;
      end
      ST_WR: begin
        s_awvalid  = m1_awvalid;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready;
        if (s_bvalid & m1_bready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
